rpsc_hv_sequencer: RTL and testbench

- Power-up/power-down sequencer for the RPSC grid-1 (G1) and anode HV supplies, sitting above the card-2 interlock logic.
- On an operator start it enables the G1 supply, waits for a settled G1_OK, then enables the anode supply and waits for AN_OK.
- Shutdown is ordered: anode off first, discharge wait, then G1 off.
- Any interlock loss or timeout trips both supplies off at once and latches a fault code until cleared.

---
 rtl/rpsc_hv_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rpsc_hv_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_hv_sequencer.sv
// RPSC HV sequencer: brings up G1 then anode, shuts down anode-first, and trips both on interlock loss.
// Outputs decode registered state only (1-cycle response to inputs); no backpressure, inputs sampled every cycle.
module rpsc_hv_sequencer #(
    parameter int CNT_WIDTH     = 22,
    parameter int G1_TIMEOUT    = 2343750,
    parameter int AN_TIMEOUT    = 3125000,
    parameter int SETTLE_CYC    = 78125,
    parameter int DISCHARGE_CYC = 390625
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_fault,
    input  logic       emergency,
    input  logic       g1_perm,
    input  logic       an_perm,
    input  logic       g1_ok,
    input  logic       an_ok,
    output logic       g1_on,
    output logic       an_on,
    output logic [2:0] state,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_G1_WAIT  = 3'd1,
        ST_AN_WAIT  = 3'd2,
        ST_RUN      = 3'd3,
        ST_SHUTDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] G1_LAST  = CNT_WIDTH'(G1_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] AN_LAST  = CNT_WIDTH'(AN_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] SET_LAST = CNT_WIDTH'(SETTLE_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] DIS_LAST = CNT_WIDTH'(DISCHARGE_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0]   scnt_q, scnt_d;
    logic [2:0]             fault_code_q, fault_code_d;

    logic                   in_idle, in_g1w, in_anw, in_run, in_shd, in_flt;
    logic                   g1_active, an_active;
    logic                   mon_ok;
    logic                   g1_adv, an_adv;
    logic [2:0]             cause;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_g1w    = (state_q == ST_G1_WAIT);
    assign in_anw    = (state_q == ST_AN_WAIT);
    assign in_run    = (state_q == ST_RUN);
    assign in_shd    = (state_q == ST_SHUTDOWN);
    assign in_flt    = (state_q == ST_FAULT);
    assign g1_active = in_g1w | in_anw | in_run | in_shd;
    assign an_active = in_anw | in_run;

    // Settle counter follows the feedback of whichever supply is currently ramping.
    assign mon_ok = (in_g1w & g1_ok) | (in_anw & an_ok);
    assign g1_adv = in_g1w & g1_ok & (scnt_q == SET_LAST);
    assign an_adv = in_anw & an_ok & (scnt_q == SET_LAST);

    always_comb begin
        cause = 3'd0;
        if ((in_idle | g1_active) && emergency) begin
            cause = 3'd1;
        end else if (g1_active && !g1_perm) begin
            cause = 3'd2;
        end else if (an_active && !an_perm) begin
            cause = 3'd3;
        end else if (in_g1w && (tcnt_q == G1_LAST) && !g1_adv) begin
            cause = 3'd4;
        end else if (in_anw && (tcnt_q == AN_LAST) && !an_adv) begin
            cause = 3'd5;
        end else if (an_active && !g1_ok) begin
            cause = 3'd6;
        end else if (in_run && !an_ok) begin
            cause = 3'd7;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;

        if (cause != 3'd0) begin
            state_d      = ST_FAULT;
            fault_code_d = cause;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && g1_perm && an_perm && !emergency) begin
                        state_d = ST_G1_WAIT;
                    end
                end
                ST_G1_WAIT: begin
                    if (stop) begin
                        state_d = ST_SHUTDOWN;
                    end else if (g1_adv) begin
                        state_d = ST_AN_WAIT;
                    end
                end
                ST_AN_WAIT: begin
                    if (stop) begin
                        state_d = ST_SHUTDOWN;
                    end else if (an_adv) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_SHUTDOWN;
                    end
                end
                ST_SHUTDOWN: begin
                    if (tcnt_q == DIS_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // Clear is unconditional; a still-present cause re-trips from IDLE or on the next start.
                    if (clear_fault) begin
                        state_d      = ST_IDLE;
                        fault_code_d = 3'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tcnt_d = CNT_MAX;
        scnt_d = CNT_MAX;
        if (state_d != state_q) begin
            tcnt_d = '0;
            scnt_d = '0;
        end else begin
            tcnt_d = (tcnt_q == CNT_MAX) ? tcnt_q : (tcnt_q + CNT_ONE);
            if (!mon_ok) begin
                scnt_d = '0;
            end else begin
                scnt_d = (scnt_q == CNT_MAX) ? scnt_q : (scnt_q + CNT_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tcnt_q       <= '0;
            scnt_q       <= '0;
            fault_code_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            scnt_q       <= scnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign g1_on      = g1_active;
    assign an_on      = an_active;
    assign fault      = in_flt;
    assign state      = state_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Bench for rpsc_hv_sequencer: directed stimulus pushes per-cycle expected state/fault_code into a
// scoreboard queue tagged with the target cycle; an independent monitor pops and compares after each edge.
module tb_rpsc_hv_sequencer;

    logic       clk, reset;
    logic       start, stop, clear_fault, emergency, g1_perm, an_perm, g1_ok, an_ok;
    logic       g1_on, an_on, fault;
    logic [2:0] state, fault_code;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;
    int tag      = 0;

    typedef struct {
        int         cyc;
        int         tag;
        logic [2:0] st;
        logic [2:0] code;
    } exp_t;

    exp_t exp_q[$];

    rpsc_hv_sequencer #(
        .CNT_WIDTH    (22),
        .G1_TIMEOUT   (10),
        .AN_TIMEOUT   (12),
        .SETTLE_CYC   (3),
        .DISCHARGE_CYC(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .clear_fault(clear_fault),
        .emergency  (emergency),
        .g1_perm    (g1_perm),
        .an_perm    (an_perm),
        .g1_ok      (g1_ok),
        .an_ok      (an_ok),
        .g1_on      (g1_on),
        .an_on      (an_on),
        .state      (state),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {g1_on, an_on, fault} expected for a given state encoding
    function automatic logic [2:0] decode(input logic [2:0] s);
        case (s)
            3'd1, 3'd4: return 3'b100;
            3'd2, 3'd3: return 3'b110;
            3'd5:       return 3'b001;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic step(input logic [2:0] st, input logic [2:0] code);
        exp_t e;
        e.cyc  = cyc_n + 1;
        e.tag  = tag;
        e.st   = st;
        e.code = code;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [2:0] st, input logic [2:0] code);
        logic [2:0] d;
        d = decode(st);
        n_checks++;
        if ({state, fault_code, g1_on, an_on, fault} !== {st, code, d}) begin
            n_errors++;
            $display("FAIL %s: got state=%0d code=%0d g1_on=%b an_on=%b fault=%b, expected state=%0d code=%0d g1_on=%b an_on=%b fault=%b",
                     name, state, fault_code, g1_on, an_on, fault, st, code, d[2], d[1], d[0]);
        end
    endtask

    task automatic clear_to_idle();
        clear_fault = 1'b1;
        step(3'd0, 3'd0);
        clear_fault = 1'b0;
    endtask

    // From IDLE with g1_ok=an_ok=1: 3 cycles G1_WAIT, 3 cycles AN_WAIT, then RUN.
    task automatic to_run();
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        step(3'd2, 3'd0);
        step(3'd2, 3'd0);
        step(3'd2, 3'd0);
        step(3'd3, 3'd0);
    endtask

    // Monitor: after every edge, compare all expectations targeted at this cycle.
    initial begin
        exp_t e;
        logic [2:0] d;
        forever begin
            @(posedge clk);
            cyc_n = cyc_n + 1;
            #2;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
                e = exp_q.pop_front();
                d = decode(e.st);
                n_checks++;
                if (e.cyc != cyc_n) begin
                    n_errors++;
                    $display("FAIL scn%0d stale: entry for cycle %0d seen at cycle %0d", e.tag, e.cyc, cyc_n);
                end else if ({state, fault_code, g1_on, an_on, fault} !== {e.st, e.code, d}) begin
                    n_errors++;
                    $display("FAIL scn%0d cyc%0d: got state=%0d code=%0d g1_on=%b an_on=%b fault=%b, expected state=%0d code=%0d g1_on=%b an_on=%b fault=%b",
                             e.tag, cyc_n, state, fault_code, g1_on, an_on, fault,
                             e.st, e.code, d[2], d[1], d[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; stop = 1'b0; clear_fault = 1'b0; emergency = 1'b0;
        g1_perm = 1'b1; an_perm = 1'b1; g1_ok = 1'b0; an_ok = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 check_now("reset_state", 3'd0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        step(3'd0, 3'd0);

        // 1: nominal bring-up, 5 cycles G1_WAIT then 4 cycles AN_WAIT
        tag = 1;
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        g1_ok = 1'b1;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        step(3'd2, 3'd0);
        step(3'd2, 3'd0);
        an_ok = 1'b1;
        step(3'd2, 3'd0);
        step(3'd2, 3'd0);
        step(3'd3, 3'd0);
        step(3'd3, 3'd0);
        step(3'd3, 3'd0);

        // 2: ordered stop, anode off then G1 off 5 cycles later
        tag = 2;
        stop = 1'b1;
        step(3'd4, 3'd0);
        stop = 1'b0;
        repeat (4) step(3'd4, 3'd0);
        step(3'd0, 3'd0);
        g1_ok = 1'b0;
        an_ok = 1'b0;
        step(3'd0, 3'd0);

        // 3: G1 timeout after 10 cycles, then settle restart on a g1_ok drop
        tag = 3;
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        repeat (9) step(3'd1, 3'd0);
        step(3'd5, 3'd4);
        step(3'd5, 3'd4);
        clear_to_idle();
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        g1_ok = 1'b1;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        g1_ok = 1'b0;
        step(3'd1, 3'd0);
        g1_ok = 1'b1;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        step(3'd2, 3'd0);
        an_ok = 1'b1;
        step(3'd2, 3'd0);
        step(3'd2, 3'd0);
        step(3'd3, 3'd0);

        // 4: simultaneous faults in RUN resolve to emergency; clear works even with cause present
        tag = 4;
        emergency = 1'b1;
        g1_perm = 1'b0;
        an_ok = 1'b0;
        step(3'd5, 3'd1);
        g1_perm = 1'b1;
        clear_to_idle();
        step(3'd5, 3'd1);
        emergency = 1'b0;
        clear_to_idle();
        g1_ok = 1'b0;

        // 5: rejected start, stop/start/an_perm ignored in SHUTDOWN, g1_perm trips it
        tag = 5;
        an_perm = 1'b0;
        start = 1'b1;
        step(3'd0, 3'd0);
        step(3'd0, 3'd0);
        start = 1'b0;
        an_perm = 1'b1;
        step(3'd0, 3'd0);
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        stop = 1'b1;
        step(3'd4, 3'd0);
        step(3'd4, 3'd0);
        start = 1'b1;
        an_perm = 1'b0;
        step(3'd4, 3'd0);
        g1_perm = 1'b0;
        step(3'd5, 3'd2);
        stop = 1'b0;
        start = 1'b0;
        an_perm = 1'b1;
        g1_perm = 1'b1;
        clear_to_idle();

        // 7: remaining fault codes
        tag = 7;
        g1_ok = 1'b1;
        an_ok = 1'b1;
        to_run();
        an_ok = 1'b0;
        step(3'd5, 3'd7);
        an_ok = 1'b1;
        clear_to_idle();
        to_run();
        g1_ok = 1'b0;
        step(3'd5, 3'd6);
        g1_ok = 1'b1;
        clear_to_idle();
        to_run();
        an_perm = 1'b0;
        step(3'd5, 3'd3);
        an_perm = 1'b1;
        clear_to_idle();
        an_ok = 1'b0;
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        step(3'd2, 3'd0);
        repeat (11) step(3'd2, 3'd0);
        step(3'd5, 3'd5);
        clear_to_idle();

        // 6: async reset mid-AN_WAIT, then normal restart
        tag = 6;
        start = 1'b1;
        step(3'd1, 3'd0);
        start = 1'b0;
        step(3'd1, 3'd0);
        step(3'd1, 3'd0);
        step(3'd2, 3'd0);
        step(3'd2, 3'd0);
        #3 reset = 1'b0;
        #1 check_now("async_reset", 3'd0, 3'd0);
        @(posedge clk);
        #1;
        step(3'd0, 3'd0);
        reset = 1'b1;
        step(3'd0, 3'd0);
        an_ok = 1'b1;
        to_run();
        step(3'd3, 3'd0);

        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
